// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Slot timing defaults target a 4-digit display on a 74HC138-style decoder plus a 4511.
package seg_scan_pkg;

    localparam int NDIG          = 4;
    localparam int DEF_CLK_DIV   = 1000;
    localparam int DEF_BLANK_CYC = 16;

    // Per-slot FSM encoding: a blanking gap followed by the visible portion
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] dig_idx_t;

    function automatic logic is_zero(bcd_t v);
        return v == 4'd0;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bus between the frame writer / display pins and the scan controller.
// Handshake: wr_req is held with wr_addr/wr_data stable until wr_ack pulses for one cycle; an ack cycle never accepts a second write.
interface seg_scan_if;
    import seg_scan_pkg::*;

    logic       wr_req;
    dig_idx_t   wr_addr;
    bcd_t       wr_data;
    logic       wr_ack;
    logic       lzb_en;
    dig_idx_t   digit_sel;
    logic       dg_en;
    bcd_t       bcd_out;
    logic       bi_n;
    logic       frame_tick;
    logic [0:0] st_dbg;

    modport master (
        output wr_req, wr_addr, wr_data, lzb_en,
        input  wr_ack, digit_sel, dg_en, bcd_out, bi_n, frame_tick, st_dbg
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, lzb_en,
        output wr_ack, digit_sel, dg_en, bcd_out, bi_n, frame_tick, st_dbg
    );

endinterface

// File: rtl/seg_slot_timer.sv
// Per-digit slot counter: produces the BLANK/SHOW state and the end-of-slot / end-of-frame strobes.
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic       Clk,
    input  logic       Aclr,
    input  dig_idx_t   digit_sel,
    output logic [0:0] state,
    output logic       slot_end,
    output logic       frame_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] cnt_nxt;

    assign slot_end  = (slot_cnt == CNT_MAX);
    assign frame_end = slot_end && (digit_sel == dig_idx_t'(NDIG - 1));

    always_comb begin
        cnt_nxt = slot_end ? '0 : slot_cnt + 1'b1;
    end

    // State is registered from the next count so it always matches slot_cnt
    always_ff @(posedge Clk) begin
        if (Aclr) begin
            slot_cnt <= '0;
            state    <= ST_BLANK;
        end else begin
            slot_cnt <= cnt_nxt;
            state    <= (cnt_nxt < BLANK_LIM) ? ST_BLANK : ST_SHOW;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit scan controller: shadow/active frame buffers, write handshake, digit rotation,
// leading-zero blanking and registered-only output drive for the decoder and 4511.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic       Clk,
    input  logic       Aclr,
    seg_scan_if.slave  bus
);

    logic [0:0] state;
    logic       slot_end;
    logic       frame_end;

    dig_idx_t   digit_sel_q;
    bcd_t       shadow [NDIG];
    bcd_t       active [NDIG];
    logic       wr_ack_q;
    logic       frame_tick_q;
    logic       lzb_q;

    logic [NDIG-2:0] lead_zero;
    logic [NDIG-1:0] blank_mask;
    logic            show;

    seg_slot_timer #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .Clk       (Clk),
        .Aclr      (Aclr),
        .digit_sel (digit_sel_q),
        .state     (state),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    always_ff @(posedge Clk) begin
        if (Aclr) begin
            digit_sel_q  <= '0;
            wr_ack_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            lzb_q        <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            lzb_q        <= bus.lzb_en;
            frame_tick_q <= frame_end;

            if (bus.wr_req && !wr_ack_q) begin
                wr_ack_q              <= 1'b1;
                shadow[bus.wr_addr]   <= bus.wr_data;
            end else begin
                wr_ack_q <= 1'b0;
            end

            if (slot_end) begin
                digit_sel_q <= digit_sel_q + 1'b1;
            end

            // Copies pre-edge shadow, so a write landing on this edge waits a frame
            if (frame_end) begin
                for (int i = 0; i < NDIG; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // Digit k is a leading zero when it and every digit to its left are zero
    always_comb begin
        lead_zero[0] = is_zero(active[0]);
        for (int k = 1; k < NDIG - 1; k++) begin
            lead_zero[k] = lead_zero[k-1] && is_zero(active[k]);
        end
        blank_mask = {1'b0, lead_zero & {(NDIG-1){lzb_q}}};
    end

    assign show           = (state == ST_SHOW);
    assign bus.digit_sel  = digit_sel_q;
    assign bus.dg_en      = show;
    assign bus.bcd_out    = active[digit_sel_q];
    assign bus.bi_n       = show && !blank_mask[digit_sel_q];
    assign bus.wr_ack     = wr_ack_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.st_dbg     = state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYC=2: a reference model pushes expected outputs per cycle.
module tb_seg_scan_ctrl;
  import seg_scan_pkg::*;

  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;

  logic Clk  = 1'b0;
  logic Aclr = 1'b1;

  seg_scan_if bus();

  seg_scan_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .Clk  (Clk),
    .Aclr (Aclr),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_cnt = 0;
  int         m_dig = 0;
  logic [3:0] m_shadow [4];
  logic [3:0] m_active [4];
  logic       m_lzb  = 1'b0;
  logic       m_ack  = 1'b0;
  logic       m_tick = 1'b0;

  logic [9:0] exp_q[$];

  function automatic logic [9:0] model_out();
    logic show, zl, blank, bi;
    show = (m_cnt >= BLANK_CYC);
    zl = 1'b1;
    for (int k = 0; k <= m_dig; k++) zl = zl && (m_active[k] == 4'd0);
    blank = m_lzb && (m_dig < 3) && zl;
    bi = show && !blank;
    return {m_ack, 2'(m_dig), show, m_active[m_dig], bi, m_tick};
  endfunction

  // Advance the model across one rising edge using the currently driven inputs
  task automatic model_step();
    logic ack_n, swap;
    if (Aclr) begin
      m_cnt = 0; m_dig = 0; m_lzb = 1'b0; m_ack = 1'b0; m_tick = 1'b0;
      for (int i = 0; i < 4; i++) begin m_shadow[i] = 4'd0; m_active[i] = 4'd0; end
    end else begin
      ack_n = bus.wr_req && !m_ack;
      swap  = (m_cnt == CLK_DIV - 1) && (m_dig == 3);
      if (swap) for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
      if (ack_n) m_shadow[bus.wr_addr] = bus.wr_data;
      m_ack  = ack_n;
      m_tick = swap;
      if (m_cnt == CLK_DIV - 1) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % 4;
      end else begin
        m_cnt++;
      end
      m_lzb = bus.lzb_en;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [9:0] exp;
    model_step();
    exp_q.push_back(model_out());
    @(negedge Clk);
    exp = exp_q.pop_front();
    check_eq("wr_ack",     32'(bus.wr_ack),     32'(exp[9]));
    check_eq("digit_sel",  32'(bus.digit_sel),  32'(exp[8:7]));
    check_eq("dg_en",      32'(bus.dg_en),      32'(exp[6]));
    check_eq("bcd_out",    32'(bus.bcd_out),    32'(exp[5:2]));
    check_eq("bi_n",       32'(bus.bi_n),       32'(exp[1]));
    check_eq("frame_tick", 32'(bus.frame_tick), 32'(exp[0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus.wr_ack) break;
    end
    check_eq("wr_ack_seen", 32'(bus.wr_ack), 32'd1);
    bus.wr_req = 1'b0;
  endtask

  task automatic wait_swap_edge();
    for (int i = 0; i < 40; i++) begin
      if (m_cnt == CLK_DIV - 1 && m_dig == 3) break;
      cycle();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.wr_req  = 1'b0;
    bus.wr_addr = 2'd0;
    bus.wr_data = 4'd0;
    bus.lzb_en  = 1'b0;
    for (int i = 0; i < 4; i++) begin m_shadow[i] = 4'd0; m_active[i] = 4'd0; end

    // Reset held for three edges
    Aclr = 1'b1;
    run(3);
    Aclr = 1'b0;

    // Frame tick timing: first at 32 cycles after release, then every 32
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(); n++;
      if (bus.frame_tick) break;
    end
    check_eq("first_tick", n, 32);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(); n++;
      if (bus.frame_tick) break;
    end
    check_eq("tick_period", n, 32);

    // Single write, visible only after the next swap
    do_write(2'd2, 4'd5);
    run(64);

    // Write landing on the swap edge itself
    wait_swap_edge();
    bus.wr_addr = 2'd0;
    bus.wr_data = 4'd9;
    bus.wr_req  = 1'b1;
    cycle();
    check_eq("swap_edge_ack",  32'(bus.wr_ack),     32'd1);
    check_eq("swap_edge_tick", 32'(bus.frame_tick), 32'd1);
    bus.wr_req = 1'b0;
    run(64);

    // Leading-zero blanking on {0,0,7,0}, then all-zero, then disabled
    do_write(2'd0, 4'd0);
    do_write(2'd2, 4'd7);
    bus.lzb_en = 1'b1;
    run(64);
    do_write(2'd2, 4'd0);
    run(64);
    bus.lzb_en = 1'b0;
    run(40);

    // Random writes including out-of-range BCD values
    for (int r = 0; r < 8; r++) begin
      do_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      bus.lzb_en = 1'($urandom_range(0, 1));
      run($urandom_range(5, 40));
    end
    run(40);

    // Reset pulse during SHOW of digit 2 with a write pending
    for (int i = 0; i < 40; i++) begin
      if (m_dig == 2 && m_cnt >= BLANK_CYC) break;
      cycle();
    end
    bus.wr_addr = 2'd1;
    bus.wr_data = 4'd3;
    bus.wr_req  = 1'b1;
    Aclr = 1'b1;
    cycle();
    check_eq("aclr_no_ack", 32'(bus.wr_ack), 32'd0);
    check_eq("aclr_dg_en",  32'(bus.dg_en),  32'd0);
    Aclr = 1'b0;
    bus.wr_req = 1'b0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
